mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled only on the rising clk edge.
REQ-004 op  in  6  instruction opcode, instr[31:26] from the instruction register.
REQ-005 funct  in  6  R-type function field, instr[5:0].
REQ-006 zero  in  1  ALU zero flag for the current cycle.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 memwrite, irwrite, regwrite  out  1 each  write enables for memory, instruction register and register file.
REQ-009 regdst, memtoreg  out  1 each  write register select (1 = rd) and write data select (1 = Data register).
REQ-010 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-011 alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-012 pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-013 alucontrol  out  3  ALU operation code.
REQ-014 pcen  out  1  PC register enable.

Function
REQ-015 Control is a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; all outputs except pcen and alucontrol decode from the state alone.
REQ-016 Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-017 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1; next state is DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode: lw/sw -> MEMADR, R-type -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP, any other opcode -> FETCH.
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD: iord=1; next state MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1; next state FETCH.
REQ-021 MEMWR: iord=1, memwrite=1; next state FETCH.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, aluop=10; next state ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1; next state FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next state FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next state FETCH.
REQ-025 JUMP: pcsrc=10, pcwrite=1; next state FETCH.
REQ-026 Any output not listed for a state is 0.
REQ-027 pcen = pcwrite | (branch & zero), combinational on zero in the same cycle.
REQ-028 Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
REQ-029 ALU decode: aluop 00 -> 010 (add); 01 -> 110 (sub); 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 000.
REQ-030 An unreachable state encoding returns to FETCH on the next edge.

Reset
REQ-031 When reset=1 at a rising edge, the state becomes FETCH, regardless of the current state (including mid-instruction).
REQ-032 While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0 combinationally.
REQ-033 In the first cycle after reset deasserts, the state is FETCH with pcen=1 and irwrite=1.

Structure
REQ-034 Package mc_pkg holds the state enum, the opcode and funct constants, and the aluop encoding.
REQ-035 ALU decode is a separate combinational sub-module, aludec (inputs aluop and funct; output alucontrol), instantiated once.

Verification
REQ-036 Hold reset 2 cycles, then release -> cycle 1 is FETCH (pcen=1, irwrite=1); during reset, all four enables read 0.
REQ-037 op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; iord=1 only in cycle 4.
REQ-038 op=000100 with zero=1 in BRANCH -> pcen=1 and pcsrc=01 in cycle 3; repeat with zero=0 -> pcen=0.
REQ-039 op=000000, funct=101010 -> alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB; back to FETCH in cycle 5.
REQ-040 op=111111 -> FETCH, DECODE, FETCH with no regwrite or memwrite pulse.
REQ-041 Assert reset during MEMRD of an lw -> no MEMWB regwrite occurs; the state is FETCH after the edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU op classes and the per-state control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    aluop_t     aluop;
  } ctrl_t;

  // Moore decode: each control bit is the set of states that assert it.
  function automatic ctrl_t state_outputs(state_t s);
    ctrl_t c;
    c.iord     = (s == S_MEMRD) || (s == S_MEMWR);
    c.memwrite = (s == S_MEMWR);
    c.irwrite  = (s == S_FETCH);
    c.regwrite = (s == S_MEMWB) || (s == S_ALUWB) || (s == S_ADDIWB);
    c.regdst   = (s == S_ALUWB);
    c.memtoreg = (s == S_MEMWB);
    c.alusrca  = (s == S_MEMADR) || (s == S_EXECUTE) || (s == S_BRANCH) || (s == S_ADDIEX);
    c.alusrcb  = (s == S_FETCH)  ? 2'b01 :
                 (s == S_DECODE) ? 2'b11 :
                 ((s == S_MEMADR) || (s == S_ADDIEX)) ? 2'b10 : 2'b00;
    c.pcsrc    = (s == S_BRANCH) ? 2'b01 : (s == S_JUMP) ? 2'b10 : 2'b00;
    c.pcwrite  = (s == S_FETCH) || (s == S_JUMP);
    c.branch   = (s == S_BRANCH);
    c.aluop    = (s == S_EXECUTE) ? ALUOP_FUNCT : (s == S_BRANCH) ? ALUOP_SUB : ALUOP_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle. There is no valid/ready handshake:
// instruction fields and zero are sampled every cycle, controls are valid every cycle.
interface mc_controller_if;

  logic [5:0]     op;
  logic [5:0]     funct;
  logic           zero;
  logic           iord;
  logic           memwrite;
  logic           irwrite;
  logic           regwrite;
  logic           regdst;
  logic           memtoreg;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic [2:0]     alucontrol;
  logic           pcen;
  mc_pkg::state_t state;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, state
  );

endinterface

// File: rtl/mc_controller_aludec.sv
// Combinational ALU decoder: maps the FSM's ALU op class and the R-type funct
// field to the 3-bit ALU control code.
module aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. The control word is registered alongside the
// state; pcen and alucontrol are formed combinationally from it.
module mc_controller
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_d = S_MEMRD;
        else if (bus.op == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Control word is computed from the next state so it lines up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_outputs(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_outputs(state_d);
    end
  end

  assign bus.iord     = ctrl_q.iord;
  assign bus.regdst   = ctrl_q.regdst;
  assign bus.memtoreg = ctrl_q.memtoreg;
  assign bus.alusrca  = ctrl_q.alusrca;
  assign bus.alusrcb  = ctrl_q.alusrcb;
  assign bus.pcsrc    = ctrl_q.pcsrc;
  assign bus.state    = state_q;

  // Write enables are killed while reset is high so nothing commits mid-reset.
  assign bus.memwrite = ctrl_q.memwrite & ~reset;
  assign bus.irwrite  = ctrl_q.irwrite  & ~reset;
  assign bus.regwrite = ctrl_q.regwrite & ~reset;
  assign bus.pcen     = (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero)) & ~reset;

  aludec u_aludec (
    .aluop      (ctrl_q.aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule
